// File: rtl/fft_out_scaler_if.sv
// Stream and control bundle for fft_out_scaler: input/output valid-ready
// channels plus the frame controls and overflow flag.
interface fft_out_scaler_if #(
   parameter int unsigned DATA_WIDTH = 16,
   parameter int unsigned SHIFT_MAX  = 6
);
   localparam int unsigned SW = $clog2(SHIFT_MAX + 1) + 1;

   logic                    In_Valid;
   logic                    In_Ready;
   logic [2*DATA_WIDTH-1:0] In_Data;
   logic                    Bypass;
   logic signed [SW-1:0]    Shift;
   logic                    Round_En;
   logic                    Out_Valid;
   logic                    Out_Ready;
   logic [2*DATA_WIDTH-1:0] Out_Data;
   logic                    Out_Last;
   logic                    Ovf_Flag;
   logic                    Ovf_Clr;

   modport slave (
      input  In_Valid, In_Data, Bypass, Shift, Round_En, Out_Ready, Ovf_Clr,
      output In_Ready, Out_Valid, Out_Data, Out_Last, Ovf_Flag
   );

   modport master (
      output In_Valid, In_Data, Bypass, Shift, Round_En, Out_Ready, Ovf_Clr,
      input  In_Ready, Out_Valid, Out_Data, Out_Last, Ovf_Flag
   );
endinterface

// File: rtl/fft_out_scaler.sv
// Two-stage FFT output scaler: per-frame arithmetic shift of packed {real, imag}
// samples with optional round-half-up on right shifts and saturation on left shifts.
module fft_out_scaler #(
   parameter int unsigned DATA_WIDTH = 16,
   parameter int unsigned SHIFT_MAX  = 6,
   parameter int unsigned FFT_POINTS = 64
) (
   input logic             CLK,
   input logic             RST,
   fft_out_scaler_if.slave bus
);
   localparam int unsigned SW = $clog2(SHIFT_MAX + 1) + 1;
   localparam int unsigned CW = $clog2(FFT_POINTS);
   localparam int unsigned DW = DATA_WIDTH;
   localparam logic signed [SW-1:0] SMAX_P = SW'(SHIFT_MAX);
   localparam logic signed [SW-1:0] SMAX_N = -SMAX_P;

   // Returns {overflow, result} for one component.
   function automatic logic [DW:0] f_scale(input logic [DW-1:0] x,
                                           input logic signed [SW-1:0] s,
                                           input logic rnd);
      logic signed [DW:0]           v_ext;
      logic signed [DW:0]           v_add;
      logic signed [DW+SHIFT_MAX-1:0] v_wide;
      logic [SHIFT_MAX:0]           v_hi;
      logic [SW-1:0]                v_mag;
      logic [DW:0]                  v_out;
      v_out  = {1'b0, x};
      v_ext  = '0;
      v_add  = '0;
      v_wide = '0;
      v_hi   = '0;
      v_mag  = '0;
      if (!s[SW-1] && (s != '0)) begin
         v_mag = s;
         v_ext = $signed({x[DW-1], x});
         v_add = rnd ? $signed((DW+1)'(1) << (v_mag - 1'b1)) : '0;
         v_ext = (v_ext + v_add) >>> v_mag;
         v_out = {1'b0, v_ext[DW-1:0]};
      end else if (s[SW-1]) begin
         v_mag  = -s;
         v_wide = $signed({{SHIFT_MAX{x[DW-1]}}, x});
         v_wide = v_wide <<< v_mag;
         // Bits above the new sign bit must all match it for the result to fit.
         v_hi   = v_wide[DW+SHIFT_MAX-1:DW-1];
         if (!(&v_hi) && (|v_hi)) begin
            v_out = {1'b1, x[DW-1], {(DW-1){~x[DW-1]}}};
         end else begin
            v_out = {1'b0, v_wide[DW-1:0]};
         end
      end
      return v_out;
   endfunction

   logic [CW-1:0]        r_cnt;
   logic                 r_cfg_bypass;
   logic signed [SW-1:0] r_cfg_shift;
   logic                 r_cfg_round;

   logic                 r_s1_valid;
   logic [2*DW-1:0]      r_s1_data;
   logic                 r_s1_last;
   logic signed [SW-1:0] r_s1_shift;
   logic                 r_s1_round;

   logic                 r_s2_valid;
   logic [2*DW-1:0]      r_s2_data;
   logic                 r_s2_last;
   logic                 r_ovf;

   logic                 w_s2_adv;
   logic                 w_s1_adv;
   logic                 w_in_fire;
   logic                 w_frame_start;
   logic signed [SW-1:0] w_shift_clamped;
   logic                 w_cur_bypass;
   logic signed [SW-1:0] w_cur_shift;
   logic                 w_cur_round;
   logic [DW:0]          w_res_re;
   logic [DW:0]          w_res_im;
   logic                 w_ovf;

   assign w_s2_adv      = !r_s2_valid || bus.Out_Ready;
   assign w_s1_adv      = !r_s1_valid || w_s2_adv;
   assign bus.In_Ready  = !RST && w_s1_adv;
   assign w_in_fire     = bus.In_Valid && bus.In_Ready;
   assign w_frame_start = (r_cnt == '0);

   always_comb begin
      w_shift_clamped = bus.Shift;
      if (bus.Shift > SMAX_P) begin
         w_shift_clamped = SMAX_P;
      end else if (bus.Shift < SMAX_N) begin
         w_shift_clamped = SMAX_N;
      end
   end

   // The count-0 sample uses the controls being captured alongside it.
   assign w_cur_bypass = w_frame_start ? bus.Bypass      : r_cfg_bypass;
   assign w_cur_shift  = w_frame_start ? w_shift_clamped : r_cfg_shift;
   assign w_cur_round  = w_frame_start ? bus.Round_En    : r_cfg_round;

   assign w_res_re = f_scale(r_s1_data[2*DW-1:DW], r_s1_shift, r_s1_round);
   assign w_res_im = f_scale(r_s1_data[DW-1:0], r_s1_shift, r_s1_round);
   assign w_ovf    = w_res_re[DW] || w_res_im[DW];

   always_ff @(posedge CLK) begin
      if (RST) begin
         r_cnt        <= '0;
         r_cfg_bypass <= 1'b1;
         r_cfg_shift  <= '0;
         r_cfg_round  <= 1'b0;
         r_s1_valid   <= 1'b0;
         r_s1_data    <= '0;
         r_s1_last    <= 1'b0;
         r_s1_shift   <= '0;
         r_s1_round   <= 1'b0;
         r_s2_valid   <= 1'b0;
         r_s2_data    <= '0;
         r_s2_last    <= 1'b0;
         r_ovf        <= 1'b0;
      end else begin
         if (w_in_fire) begin
            r_cnt <= r_cnt + 1'b1;
         end
         if (w_in_fire && w_frame_start) begin
            r_cfg_bypass <= bus.Bypass;
            r_cfg_shift  <= w_shift_clamped;
            r_cfg_round  <= bus.Round_En;
         end
         if (w_s1_adv) begin
            r_s1_valid <= w_in_fire;
            if (w_in_fire) begin
               r_s1_data  <= bus.In_Data;
               r_s1_last  <= (r_cnt == CW'(FFT_POINTS - 1));
               r_s1_shift <= w_cur_bypass ? '0 : w_cur_shift;
               r_s1_round <= w_cur_round;
            end
         end
         if (w_s2_adv) begin
            r_s2_valid <= r_s1_valid;
            if (r_s1_valid) begin
               r_s2_data <= {w_res_re[DW-1:0], w_res_im[DW-1:0]};
               r_s2_last <= r_s1_last;
            end
         end
         if (w_s2_adv && r_s1_valid && w_ovf) begin
            r_ovf <= 1'b1;
         end else if (bus.Ovf_Clr) begin
            r_ovf <= 1'b0;
         end
      end
   end

   assign bus.Out_Valid = r_s2_valid;
   assign bus.Out_Data  = r_s2_data;
   assign bus.Out_Last  = r_s2_last;
   assign bus.Ovf_Flag  = r_ovf;
endmodule

// File: tb/tb_fft_out_scaler.sv
// Directed bench for fft_out_scaler: fixed vectors, frame switching, backpressure
// and mid-frame reset, with an output queue filled on every accepted transfer.
module tb_fft_out_scaler;
   logic clk = 1'b0;
   logic rst;
   int   n_err = 0;
   int   n_chk = 0;
   bit   done  = 1'b0;

   logic [32:0] q_out[$];
   logic        stall_q = 1'b0;
   logic [31:0] held = '0;

   always #5 clk = ~clk;

   fft_out_scaler_if #(.DATA_WIDTH(16), .SHIFT_MAX(6)) bus ();

   fft_out_scaler #(
      .DATA_WIDTH(16),
      .SHIFT_MAX (6),
      .FFT_POINTS(64)
   ) u_dut (
      .CLK(clk),
      .RST(rst),
      .bus(bus)
   );

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
      end
   endtask

   function automatic logic [15:0] rs(input logic [15:0] x, input int s, input bit rnd);
      int v;
      v = int'($signed(x));
      if (rnd) v = v + (1 << (s - 1));
      return 16'(v >>> s);
   endfunction

   // Transfers are recorded, and held data is checked while the output stalls.
   always @(negedge clk) begin
      if (!rst) begin
         if (stall_q) begin
            chk("stall_valid", bus.Out_Valid, 1);
            chk("stall_data", bus.Out_Data, held);
         end
         if (bus.Out_Valid && bus.Out_Ready) q_out.push_back({bus.Out_Last, bus.Out_Data});
         stall_q <= bus.Out_Valid && !bus.Out_Ready;
         held    <= bus.Out_Data;
      end else begin
         stall_q <= 1'b0;
      end
   end

   task automatic sync();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      sync();
      rst = 1'b1;
      bus.In_Valid  = 1'b0;
      bus.Ovf_Clr   = 1'b0;
      bus.Out_Ready = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;
      q_out.delete();
   endtask

   task automatic drive(input logic [31:0] d, input logic signed [3:0] sh,
                        input logic rnd, input logic byp);
      int n;
      n = 0;
      bus.In_Valid = 1'b1;
      bus.In_Data  = d;
      bus.Shift    = sh;
      bus.Round_En = rnd;
      bus.Bypass   = byp;
      #1;
      while (!bus.In_Ready && n < 200) begin
         @(posedge clk);
         #2;
         n++;
      end
      if (n >= 200) chk("in_ready_timeout", bus.In_Ready, 1);
      @(posedge clk);
      #1;
      bus.In_Valid = 1'b0;
   endtask

   task automatic expect_out(input string tag, input logic [32:0] exp);
      int n;
      n = 0;
      while (q_out.size() == 0 && n < 50) begin
         @(negedge clk);
         n++;
      end
      if (q_out.size() == 0) chk({tag, "_timeout"}, q_out.size(), 1);
      else chk(tag, q_out.pop_front(), exp);
   endtask

   task automatic wait_count(input int cnt, input int budget);
      int n;
      n = 0;
      while (q_out.size() < cnt && n < budget) begin
         @(negedge clk);
         n++;
      end
      repeat (4) @(negedge clk);
      chk("out_count", q_out.size(), cnt);
   endtask

   initial begin
      #400000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1);
   end

   initial begin
      logic [15:0] xr, xi, e;
      rst = 1'b1;
      bus.In_Valid  = 1'b0;
      bus.In_Data   = '0;
      bus.Bypass    = 1'b0;
      bus.Shift     = '0;
      bus.Round_En  = 1'b0;
      bus.Out_Ready = 1'b1;
      bus.Ovf_Clr   = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk("rst_in_ready", bus.In_Ready, 0);
      chk("rst_out_valid", bus.Out_Valid, 0);
      chk("rst_out_data", bus.Out_Data, 0);
      chk("rst_out_last", bus.Out_Last, 0);
      chk("rst_ovf", bus.Ovf_Flag, 0);

      // Right shift by 6, no rounding, with latency check.
      do_reset();
      drive(32'h7FFF_8000, 4'sd6, 1'b0, 1'b0);
      @(negedge clk);
      chk("lat_cycle1_valid", bus.Out_Valid, 0);
      @(negedge clk);
      chk("lat_cycle2_valid", bus.Out_Valid, 1);
      chk("rs6_data", bus.Out_Data, 32'h01FF_FE00);
      chk("rs6_ovf", bus.Ovf_Flag, 0);
      expect_out("rs6_q", {1'b0, 32'h01FF_FE00});

      // Round-half-up.
      do_reset();
      drive(32'h005F_FFA1, 4'sd6, 1'b1, 1'b0);
      drive(32'h0060_FF9F, 4'sd6, 1'b0, 1'b0);
      expect_out("rnd_95", {1'b0, 32'h0001_FFFF});
      expect_out("rnd_96", {1'b0, 32'h0002_FFFE});

      // Bypass, zero shift, and clamping in both directions.
      do_reset();
      drive(32'h1234_8765, 4'sd6, 1'b1, 1'b1);
      expect_out("bypass", {1'b0, 32'h1234_8765});
      do_reset();
      drive(32'h7FFF_8001, 4'sd0, 1'b1, 1'b0);
      expect_out("shift0", {1'b0, 32'h7FFF_8001});
      do_reset();
      drive(32'h4000_C000, 4'sd7, 1'b0, 1'b0);
      expect_out("clamp_right", {1'b0, 32'h0100_FF00});
      do_reset();
      drive(32'h0001_FFFF, 4'b1000, 1'b0, 1'b0);
      expect_out("clamp_left", {1'b0, 32'h0040_FFC0});
      chk("clamp_left_ovf", bus.Ovf_Flag, 0);

      // Left shift saturation and sticky overflow flag.
      do_reset();
      drive(32'h2001_DFFF, -4'sd2, 1'b0, 1'b0);
      expect_out("sat", {1'b0, 32'h7FFF_8000});
      chk("ovf_set", bus.Ovf_Flag, 1);
      repeat (3) @(negedge clk);
      chk("ovf_sticky", bus.Ovf_Flag, 1);
      sync();
      bus.Ovf_Clr = 1'b1;
      sync();
      bus.Ovf_Clr = 1'b0;
      @(negedge clk);
      chk("ovf_cleared", bus.Ovf_Flag, 0);
      drive(32'h3000_0000, -4'sd2, 1'b0, 1'b0);
      bus.Ovf_Clr = 1'b1;
      sync();
      bus.Ovf_Clr = 1'b0;
      @(negedge clk);
      chk("ovf_set_wins", bus.Ovf_Flag, 1);
      expect_out("sat2", {1'b0, 32'h7FFF_0000});
      sync();
      bus.Ovf_Clr = 1'b1;
      sync();
      bus.Ovf_Clr = 1'b0;
      drive(32'h0001_FFFF, -4'sd2, 1'b0, 1'b0);
      expect_out("ls2_fit", {1'b0, 32'h0004_FFFC});
      chk("ls2_no_ovf", bus.Ovf_Flag, 0);

      // Two frames back to back; Shift changes mid-frame 0.
      do_reset();
      for (int i = 0; i < 128; i++) begin
         drive({16'(i * 16), 16'(-(i * 16))}, (i < 10) ? 4'sd1 : 4'sd3, 1'b0, 1'b0);
      end
      wait_count(128, 400);
      for (int i = 0; i < 128; i++) begin
         e = (i < 64) ? 16'(i * 8) : 16'(i * 2);
         if (q_out.size() > 0)
            chk($sformatf("frame_s%0d", i), q_out.pop_front(), {(i % 64 == 63), e, 16'(-e)});
      end

      // Random backpressure over four frames.
      do_reset();
      done = 1'b0;
      fork
         begin
            for (int i = 0; i < 256; i++) begin
               xr = 16'(i * 1237 + 5);
               drive({xr, ~xr}, 4'sd2, 1'b1, 1'b0);
            end
            done = 1'b1;
         end
         begin
            while (!done) begin
               sync();
               bus.Out_Ready = 1'($urandom_range(0, 1));
            end
            bus.Out_Ready = 1'b1;
         end
      join
      wait_count(256, 600);
      for (int i = 0; i < 256; i++) begin
         xr = 16'(i * 1237 + 5);
         xi = ~xr;
         if (q_out.size() > 0)
            chk($sformatf("bp_s%0d", i), q_out.pop_front(),
                {(i % 64 == 63), rs(xr, 2, 1'b1), rs(xi, 2, 1'b1)});
      end

      // Reset while sample 20 of a frame is offered.
      do_reset();
      for (int i = 0; i < 20; i++) drive({16'(i), 16'(i)}, 4'sd0, 1'b0, 1'b0);
      rst = 1'b1;
      bus.In_Valid = 1'b1;
      bus.In_Data  = 32'h0014_0014;
      @(negedge clk);
      chk("midrst_in_ready", bus.In_Ready, 0);
      @(posedge clk);
      @(negedge clk);
      chk("midrst_out_valid", bus.Out_Valid, 0);
      sync();
      rst = 1'b0;
      bus.In_Valid = 1'b0;
      q_out.delete();
      for (int i = 0; i < 64; i++) drive({16'(i + 100), 16'(i)}, 4'sd0, 1'b0, 1'b0);
      wait_count(64, 200);
      for (int i = 0; i < 64; i++) begin
         if (q_out.size() > 0)
            chk($sformatf("newframe_s%0d", i), q_out.pop_front(),
                {(i == 63), 16'(i + 100), 16'(i)});
      end
      chk("newframe_ovf", bus.Ovf_Flag, 0);

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end
endmodule
